// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED frame path (scheduler, driver, I2C glue).
package led_pkg;

  function automatic int latch_cycles(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction

  function automatic int refresh_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  localparam int LED_CNT     = 3;
  localparam int CLK_SPEED   = 25_000_000;
  localparam int LATCH_US    = 60;
  localparam int REFRESH_MS  = 20;
  localparam int BYTE_CNT    = 3 * LED_CNT;
  localparam int FRAME_W     = 8 * BYTE_CNT;
  localparam int IDX_W       = $clog2(BYTE_CNT);
  localparam int LATCH_CYC   = latch_cycles(CLK_SPEED, LATCH_US);
  localparam int REFRESH_CYC = refresh_cycles(CLK_SPEED, REFRESH_MS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } led_state_e;

endpackage

// File: rtl/led_gap_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags terminal count.
module led_gap_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffers LED colour bytes and sequences the serial driver with latch gap and refresh.
// state | meaning
// IDLE  | waiting for commit/pending or refresh expiry
// LOAD  | copy shadow to active frame
// START | drv_start held until driver reports busy or timeout
// SEND  | driver shifting frame_o
// LATCH | enforced idle gap after a frame
module led_frame_scheduler #(
  parameter int  LED_CNT       = 3,
  parameter int  CLK_SPEED     = 25_000_000,
  parameter int  LATCH_US      = 60,
  parameter int  REFRESH_MS    = 20,
  parameter int  START_TIMEOUT = 255,
  localparam int BYTE_CNT      = 3 * LED_CNT,
  localparam int FRAME_W       = 8 * BYTE_CNT,
  localparam int IDX_W         = $clog2(BYTE_CNT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [7:0]         wr_data,
  input  logic               commit,
  output logic [FRAME_W-1:0] frame_o,
  output logic               drv_start,
  input  logic               drv_busy,
  output logic               busy_o,
  output logic               err_o
);
  import led_pkg::*;

  localparam int GAP_CYC  = latch_cycles(CLK_SPEED, LATCH_US);
  localparam int RFSH_CYC = refresh_cycles(CLK_SPEED, REFRESH_MS);
  localparam int GAP_W    = $clog2(GAP_CYC) + 1;
  localparam int RFSH_W   = $clog2((RFSH_CYC > 1) ? RFSH_CYC : 2) + 1;
  localparam int TO_W     = $clog2(START_TIMEOUT) + 1;

  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC - 1);
  localparam logic [RFSH_W-1:0] RFSH_LOAD = RFSH_W'((RFSH_CYC == 0) ? 0 : RFSH_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(START_TIMEOUT - 1);

  led_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               gap_load, gap_zero, rfsh_zero, rfsh_fire;

  led_gap_timer #(.W(GAP_W), .RST_VAL('0)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (state_q == LATCH),
    .zero_o   (gap_zero)
  );

  // Held at full count outside IDLE, so the refresh interval restarts on every return.
  led_gap_timer #(.W(RFSH_W), .RST_VAL(RFSH_LOAD)) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q != IDLE),
    .load_val (RFSH_LOAD),
    .en       (state_q == IDLE),
    .zero_o   (rfsh_zero)
  );

  assign rfsh_fire = (RFSH_CYC != 0) && rfsh_zero;

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < BYTE_CNT; k++) begin
      if (wr_valid && (int'(wr_index) == k)) begin
        for (int i = 0; i < 8; i++) shadow_d[8*k+i] = wr_data[7-i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    pending_d = pending_q | commit;
    err_d     = err_q;
    to_cnt_d  = '0;
    gap_load  = 1'b0;
    drv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || commit) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end else if (rfsh_fire) begin
          state_d = START;
        end
      end
      LOAD: begin
        frame_d = shadow_q;
        state_d = START;
      end
      START: begin
        drv_start = 1'b1;
        to_cnt_d  = to_cnt_q + 1'b1;
        if (drv_busy) begin
          state_d = SEND;
        end else if (to_cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          state_d  = LATCH;
          gap_load = 1'b1;
        end
      end
      SEND: begin
        if (!drv_busy) begin
          state_d  = LATCH;
          gap_load = 1'b1;
        end
      end
      LATCH: begin
        if (gap_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      frame_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign frame_o = frame_q;
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with a simple start/busy driver model.
module tb_led_frame_scheduler;

  localparam logic [71:0] FRAME_1_9 = 72'h90_10_E0_60_A0_20_C0_40_80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_index = '0;
  logic [7:0]  wr_data = '0;
  logic        commit = 1'b0;
  logic        drv_busy = 1'b0;
  logic [71:0] frame_o;
  logic        drv_start, busy_o, err_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start = 0;
  int last_fall = 0;
  int bfm_cnt = 0;
  bit bfm_en = 1'b1;
  logic prev_start = 1'b0;

  led_frame_scheduler #(
    .LED_CNT(3), .CLK_SPEED(10_000_000), .LATCH_US(60), .REFRESH_MS(1), .START_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data),
    .commit(commit), .frame_o(frame_o), .drv_start(drv_start), .drv_busy(drv_busy),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: busy rises 2 cycles after start is seen and stays high 100 cycles.
  always @(negedge clk) begin
    if (drv_start && !prev_start) begin
      n_starts++;
      last_start = cyc;
    end
    prev_start = drv_start;
    if (reset) begin
      bfm_cnt  = 0;
      drv_busy = 1'b0;
    end else if (bfm_cnt == 0) begin
      if (drv_start && bfm_en) bfm_cnt = 1;
    end else begin
      bfm_cnt++;
      if (bfm_cnt == 3) begin
        drv_busy = 1'b1;
      end else if (bfm_cnt == 103) begin
        drv_busy  = 1'b0;
        bfm_cnt   = 0;
        last_fall = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_index = 4'(idx);
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && busy_o; i++) step();
    check_eq(tag, 72'(busy_o), 72'd0);
  endtask

  task automatic wait_starts(input string tag, input int target, input int max);
    for (int i = 0; i < max && n_starts < target; i++) step();
    check_eq(tag, 72'(n_starts), 72'(target));
  endtask

  task automatic wait_busy(input string tag, input logic val, input int max);
    for (int i = 0; i < max && drv_busy !== val; i++) step();
    check_eq(tag, 72'(drv_busy), 72'(val));
  endtask

  int c0, f1, s0, idle_at, first;

  initial begin
    repeat (3) step();
    check_eq("rst_frame", frame_o, 72'd0);
    check_eq("rst_drv_start", 72'(drv_start), 72'd0);
    check_eq("rst_busy", 72'(busy_o), 72'd0);
    check_eq("rst_err", 72'(err_o), 72'd0);
    reset = 1'b0;
    step();

    // Basic frame: bytes 1..9, commit latency of two cycles
    for (int k = 0; k < 9; k++) wr(k, 8'(k + 1));
    c0 = cyc;
    pulse_commit();
    check_eq("t1_load_no_start", 72'(drv_start), 72'd0);
    check_eq("t1_load_busy", 72'(busy_o), 72'd1);
    step();
    check_eq("t1_start", 72'(drv_start), 72'd1);
    check_eq("t1_start_cycle", 72'(last_start - c0), 72'd2);
    check_eq("t1_frame", frame_o, FRAME_1_9);
    check_eq("t1_byte0", 72'(frame_o[7:0]), 72'h80);
    check_eq("t1_byte8", 72'(frame_o[71:64]), 72'h90);
    wait_idle("t1_idle", 1000);
    check_eq("t1_one_frame", 72'(n_starts), 72'd1);
    check_eq("t1_gap", 72'(cyc - last_fall), 72'd601);

    // Commits during SEND and LATCH collapse into one extra frame after the full gap
    s0 = n_starts;
    pulse_commit();
    wait_busy("t2_busy_hi", 1'b1, 50);
    pulse_commit();
    wait_busy("t2_busy_lo", 1'b0, 200);
    f1 = last_fall;
    repeat (10) step();
    pulse_commit();
    wait_starts("t2_second_start", s0 + 2, 1000);
    check_eq("t2_gap_to_start", 72'(last_start - f1), 72'd603);
    wait_idle("t2_idle", 1000);
    repeat (700) step();
    check_eq("t2_no_third", 72'(n_starts), 72'(s0 + 2));

    // Out-of-range writes are dropped
    wr(9, 8'hFF);
    wr(15, 8'hFF);
    s0 = n_starts;
    pulse_commit();
    wait_starts("t3_start", s0 + 1, 20);
    wait_idle("t3_idle", 1000);
    check_eq("t3_frame_kept", frame_o, FRAME_1_9);

    // Periodic refresh resends the active frame
    idle_at = cyc;
    s0 = n_starts;
    wait_starts("t4_refresh1", s0 + 1, 10100);
    check_eq("t4_refresh_delay", 72'(last_start - idle_at), 72'd10000);
    check_eq("t4_frame", frame_o, FRAME_1_9);
    first = last_start;
    wait_starts("t4_refresh2", s0 + 2, 11000);
    check_eq("t4_period", 72'(last_start - first), 72'd10703);
    wait_idle("t4_idle", 1000);

    // Driver never acknowledges: timeout, sticky error, recovery
    bfm_en = 1'b0;
    s0 = n_starts;
    pulse_commit();
    wait_starts("t5_start", s0 + 1, 10);
    first = last_start;
    while (cyc < first + 254) step();
    check_eq("t5_still_start", 72'(drv_start), 72'd1);
    check_eq("t5_no_err_yet", 72'(err_o), 72'd0);
    step();
    check_eq("t5_err", 72'(err_o), 72'd1);
    check_eq("t5_start_drop", 72'(drv_start), 72'd0);
    check_eq("t5_in_latch", 72'(busy_o), 72'd1);
    wait_idle("t5_idle", 700);
    bfm_en = 1'b1;
    wr_valid = 1'b1;
    wr_index = 4'd0;
    wr_data  = 8'hAA;
    commit   = 1'b1;
    step();
    wr_valid = 1'b0;
    commit   = 1'b0;
    wait_starts("t5_recover_start", s0 + 2, 20);
    wait_idle("t5_recover_idle", 1000);
    check_eq("t5_same_cycle_write", 72'(frame_o[7:0]), 72'h55);
    check_eq("t5_byte1", 72'(frame_o[15:8]), 72'h40);
    check_eq("t5_err_sticky", 72'(err_o), 72'd1);

    // Reset during SEND aborts and clears everything
    pulse_commit();
    wait_busy("t6_busy_hi", 1'b1, 50);
    step();
    reset = 1'b1;
    step();
    check_eq("t6_frame", frame_o, 72'd0);
    check_eq("t6_drv_start", 72'(drv_start), 72'd0);
    check_eq("t6_busy", 72'(busy_o), 72'd0);
    check_eq("t6_err", 72'(err_o), 72'd0);
    reset = 1'b0;
    s0 = n_starts;
    repeat (200) step();
    check_eq("t6_no_send", 72'(n_starts), 72'(s0));
    pulse_commit();
    wait_starts("t6_commit_start", s0 + 1, 20);
    wait_idle("t6_idle", 1000);
    check_eq("t6_shadow_cleared", frame_o, 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
